// File: rtl/isu_ex_latch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | isu_ex_latch_pkg                                                           |
// | Issue-packet layout and issue-port numbering shared by the priority        |
// | decoder and the issue-to-execute boundary register.                        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package isu_ex_latch_pkg;

  localparam int IS_INST_WIDTH    = 66;
  localparam int ISQ_IDX_BITS_NUM = 6;

  localparam int IS_BIT_INST_VLD  = 65;
  localparam int IS_BIT_IDX       = 64;
  localparam int IS_PREG_BITS     = 6;

  localparam int FUN_MULT_BIT     = 0;
  localparam int FUN_ADD1_BIT     = 1;
  localparam int FUN_ADD2_BIT     = 2;
  localparam int FUN_ADDR_BIT     = 3;
  localparam int FUN_NUM          = 4;

  localparam int MUL_CNT_BITS     = 4;

  typedef enum logic [1:0] {
    PORT_MULT = 2'd0,
    PORT_ALU1 = 2'd1,
    PORT_ALU2 = 2'd2,
    PORT_ADDR = 2'd3
  } isu_port_e;

  typedef struct packed {
    logic                                  vld;
    logic [ISQ_IDX_BITS_NUM-1:0]           idx;
    logic [IS_INST_WIDTH-ISQ_IDX_BITS_NUM-IS_PREG_BITS-2:0] payload;
    logic [IS_PREG_BITS-1:0]               preg;
  } is_pkt_t;

  function automatic logic is_pkt_vld(input logic [IS_INST_WIDTH-1:0] pkt);
    return pkt[IS_BIT_INST_VLD];
  endfunction

endpackage : isu_ex_latch_pkg
`default_nettype wire

// File: rtl/isu_ex_latch_port_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | isu_port_reg                                                               |
// | One issue-port packet register: load on accept, optional hold, bubble      |
// | otherwise; flush clears only the valid bit of whatever is held.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module isu_port_reg #(
  parameter int WIDTH   = 66,
  parameter int VLD_BIT = 65
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pkt_i,
  input  logic             acc_i,
  input  logic             hold_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] pkt_o
);

  logic [WIDTH-1:0] pkt_q;
  logic [WIDTH-1:0] pkt_d;

  always_comb begin
    pkt_d = '0;
    if (flush_i) begin
      pkt_d          = pkt_q;
      pkt_d[VLD_BIT] = 1'b0;
    end else if (acc_i) begin
      pkt_d = pkt_i;
    end else if (hold_i) begin
      pkt_d = pkt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_q <= '0;
    end else begin
      pkt_q <= pkt_d;
    end
  end

  assign pkt_o = pkt_q;

endmodule : isu_port_reg
`default_nettype wire

// File: rtl/isu_ex_latch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | isu_ex_latch                                                               |
// | Issue-to-execute boundary register for the mult/ALU1/ALU2/addr ports,      |
// | with multiplier occupancy tracking and the same-cycle ready vector.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module isu_ex_latch #(
  parameter int IS_INST_WIDTH    = isu_ex_latch_pkg::IS_INST_WIDTH,
  parameter int ISQ_IDX_BITS_NUM = isu_ex_latch_pkg::ISQ_IDX_BITS_NUM,
  parameter int MUL_LAT          = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [IS_INST_WIDTH-1:0] mul_ins_to_rf,
  input  logic [IS_INST_WIDTH-1:0] alu1_ins_to_rf,
  input  logic [IS_INST_WIDTH-1:0] alu2_ins_to_rf,
  input  logic [IS_INST_WIDTH-1:0] adr_ins_to_rf,
  input  logic                     mem_stall,
  input  logic                     flush,
  output logic [3:0]               fun_rdy_frm_exe,
  output logic [IS_INST_WIDTH-1:0] mul_ins_to_ex,
  output logic [IS_INST_WIDTH-1:0] alu1_ins_to_ex,
  output logic [IS_INST_WIDTH-1:0] alu2_ins_to_ex,
  output logic [IS_INST_WIDTH-1:0] adr_ins_to_ex,
  output logic                     issue_err
);

  import isu_ex_latch_pkg::*;

  localparam logic [MUL_CNT_BITS-1:0] MUL_LAT_LOAD = MUL_CNT_BITS'(MUL_LAT - 1);

  if (MUL_LAT < 1 || MUL_LAT > 15 || ISQ_IDX_BITS_NUM >= IS_INST_WIDTH) begin : g_param_check
    $error("isu_ex_latch: illegal parameter combination");
  end

  logic [IS_INST_WIDTH-1:0]  pkt_rf [FUN_NUM];
  logic [IS_INST_WIDTH-1:0]  pkt_ex [FUN_NUM];
  logic [FUN_NUM-1:0]        rdy;
  logic [FUN_NUM-1:0]        vld;
  logic [FUN_NUM-1:0]        acc;
  logic [FUN_NUM-1:0]        hold;

  logic [MUL_CNT_BITS-1:0]   mul_cnt_q;
  logic [MUL_CNT_BITS-1:0]   mul_cnt_d;
  logic                      issue_err_q;
  logic                      issue_err_d;

  assign pkt_rf[FUN_MULT_BIT] = mul_ins_to_rf;
  assign pkt_rf[FUN_ADD1_BIT] = alu1_ins_to_rf;
  assign pkt_rf[FUN_ADD2_BIT] = alu2_ins_to_rf;
  assign pkt_rf[FUN_ADDR_BIT] = adr_ins_to_rf;

  // Deliberate same-cycle path from flush/mem_stall into the decoder.
  always_comb begin
    rdy               = '0;
    rdy[FUN_MULT_BIT] = (mul_cnt_q == '0) & ~flush;
    rdy[FUN_ADD1_BIT] = ~flush;
    rdy[FUN_ADD2_BIT] = ~flush;
    rdy[FUN_ADDR_BIT] = ~mem_stall & ~flush;
  end

  for (genvar p = 0; p < FUN_NUM; p++) begin : g_port
    assign vld[p]  = is_pkt_vld(pkt_rf[p]);
    assign acc[p]  = vld[p] & rdy[p];
    // Only the address path waits on the memory side; other ports bubble.
    assign hold[p] = (p == FUN_ADDR_BIT) ? mem_stall : 1'b0;

    isu_port_reg #(
      .WIDTH   (IS_INST_WIDTH),
      .VLD_BIT (IS_BIT_INST_VLD)
    ) u_port_reg (
      .clk     (clk),
      .rst_n   (rst_n),
      .pkt_i   (pkt_rf[p]),
      .acc_i   (acc[p]),
      .hold_i  (hold[p]),
      .flush_i (flush),
      .pkt_o   (pkt_ex[p])
    );
  end

  always_comb begin
    mul_cnt_d = mul_cnt_q;
    if (flush) begin
      mul_cnt_d = '0;
    end else if (acc[FUN_MULT_BIT]) begin
      mul_cnt_d = MUL_LAT_LOAD;
    end else if (mul_cnt_q != '0) begin
      mul_cnt_d = mul_cnt_q - MUL_CNT_BITS'(1);
    end
  end

  // Sticky until reset; a packet offered to a blocked port is dropped.
  always_comb begin
    issue_err_d = issue_err_q | (~flush & (|(vld & ~rdy)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_cnt_q   <= '0;
      issue_err_q <= 1'b0;
    end else begin
      mul_cnt_q   <= mul_cnt_d;
      issue_err_q <= issue_err_d;
    end
  end

  assign fun_rdy_frm_exe = rdy;
  assign mul_ins_to_ex   = pkt_ex[FUN_MULT_BIT];
  assign alu1_ins_to_ex  = pkt_ex[FUN_ADD1_BIT];
  assign alu2_ins_to_ex  = pkt_ex[FUN_ADD2_BIT];
  assign adr_ins_to_ex   = pkt_ex[FUN_ADDR_BIT];
  assign issue_err       = issue_err_q;

endmodule : isu_ex_latch
`default_nettype wire

// File: tb/tb_isu_ex_latch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_isu_ex_latch                                                            |
// | Directed bench for isu_ex_latch with a cycle-level reference model.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_isu_ex_latch;

  localparam int W       = 66;
  localparam int MUL_LAT = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] mul_rf = '0, alu1_rf = '0, alu2_rf = '0, adr_rf = '0;
  logic         mem_stall = 1'b0, flush = 1'b0;
  logic [3:0]   rdy;
  logic [W-1:0] mul_ex, alu1_ex, alu2_ex, adr_ex;
  logic         err;

  always #5 clk = ~clk;

  isu_ex_latch #(
    .IS_INST_WIDTH    (W),
    .ISQ_IDX_BITS_NUM (6),
    .MUL_LAT          (MUL_LAT)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .mul_ins_to_rf   (mul_rf),
    .alu1_ins_to_rf  (alu1_rf),
    .alu2_ins_to_rf  (alu2_rf),
    .adr_ins_to_rf   (adr_rf),
    .mem_stall       (mem_stall),
    .flush           (flush),
    .fun_rdy_frm_exe (rdy),
    .mul_ins_to_ex   (mul_ex),
    .alu1_ins_to_ex  (alu1_ex),
    .alu2_ins_to_ex  (alu2_ex),
    .adr_ins_to_ex   (adr_ex),
    .issue_err       (err)
  );

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [W-1:0] mk(input int idx, input int preg);
    logic [W-1:0] v;
    v        = '0;
    v[65]    = 1'b1;
    v[64:59] = idx[5:0];
    v[5:0]   = preg[5:0];
    return v;
  endfunction

  // Reference model: the multiplier is tracked as "free from cycle N on",
  // where cycle k is the interval after the k-th edge since reset.
  logic [W-1:0] m_out [4] = '{default: '0};
  logic         m_err     = 1'b0;
  int           cyc       = 0;
  int           mul_free  = 0;
  logic [3:0]   m_r;
  logic [W-1:0] m_pk;

  function automatic logic [3:0] m_rdy();
    logic [3:0] r;
    r[0] = (cyc >= mul_free) && !flush;
    r[1] = !flush;
    r[2] = !flush;
    r[3] = !mem_stall && !flush;
    return r;
  endfunction

  function automatic logic [W-1:0] in_pkt(input int p);
    case (p)
      0:       return mul_rf;
      1:       return alu1_rf;
      2:       return alu2_rf;
      default: return adr_rf;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < 4; p++) m_out[p] = '0;
      m_err    = 1'b0;
      cyc      = 0;
      mul_free = 0;
    end else begin
      m_r = m_rdy();
      for (int p = 0; p < 4; p++) begin
        m_pk = in_pkt(p);
        if (m_pk[65] && !m_r[p] && !flush) m_err = 1'b1;
        if (flush)                 m_out[p][65] = 1'b0;
        else if (m_pk[65] && m_r[p]) m_out[p] = m_pk;
        else if (!(p == 3 && mem_stall)) m_out[p] = '0;
      end
      if (flush) mul_free = cyc + 1;
      else if (mul_rf[65] && m_r[0]) mul_free = cyc + MUL_LAT;
      cyc++;
    end
  end

  always @(negedge clk) begin
    chk("model_rdy",  {62'b0, rdy}, {62'b0, m_rdy()});
    chk("model_mul",  mul_ex,  m_out[0]);
    chk("model_alu1", alu1_ex, m_out[1]);
    chk("model_alu2", alu2_ex, m_out[2]);
    chk("model_adr",  adr_ex,  m_out[3]);
    chk("model_err",  {65'b0, err}, {65'b0, m_err});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values, before any clock edge
    #2;
    chk("rst_rdy", {62'b0, rdy}, 66'hF);
    chk("rst_mul", mul_ex, '0);
    chk("rst_adr", adr_ex, '0);
    chk("rst_err", {65'b0, err}, '0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // All four ports at once, then an idle cycle
    mul_rf = mk(3, 1); alu1_rf = mk(7, 2); alu2_rf = mk(8, 3); adr_rf = mk(12, 4);
    tick();
    mul_rf = '0; alu1_rf = '0; alu2_rf = '0; adr_rf = '0;
    @(negedge clk);
    chk("all_mul",  mul_ex,  mk(3, 1));
    chk("all_alu1", alu1_ex, mk(7, 2));
    chk("all_alu2", alu2_ex, mk(8, 3));
    chk("all_adr",  adr_ex,  mk(12, 4));
    chk("all_rdy",  {62'b0, rdy}, 66'hE);
    tick();
    @(negedge clk);
    chk("idle_mul",  mul_ex,  '0);
    chk("idle_alu1", alu1_ex, '0);
    chk("idle_adr",  adr_ex,  '0);
    tick();

    // Address stall holds the register and blocks bit3
    adr_rf = mk(20, 5);
    tick();
    adr_rf = '0; mem_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_hold", adr_ex, mk(20, 5));
      chk("stall_rdy3", {65'b0, rdy[3]}, '0);
      tick();
    end
    mem_stall = 1'b0; adr_rf = mk(21, 6);
    @(negedge clk);
    chk("unstall_rdy3", {65'b0, rdy[3]}, 66'd1);
    tick();
    adr_rf = '0;
    @(negedge clk);
    chk("unstall_adr", adr_ex, mk(21, 6));
    tick();

    // Flush while mult busy (cnt=2) and address held under stall
    mul_rf = mk(30, 7); adr_rf = mk(31, 8);
    tick();
    mul_rf = mk(32, 9); alu1_rf = mk(33, 10); adr_rf = '0;
    mem_stall = 1'b1; flush = 1'b1;
    @(negedge clk);
    chk("flush_rdy", {62'b0, rdy}, '0);
    chk("flush_pre_adr", adr_ex, mk(31, 8));
    tick();
    flush = 1'b0; mem_stall = 1'b0; mul_rf = '0; alu1_rf = '0;
    @(negedge clk);
    chk("flush_mul_vld",  {65'b0, mul_ex[65]},  '0);
    chk("flush_alu1_vld", {65'b0, alu1_ex[65]}, '0);
    chk("flush_adr_vld",  {65'b0, adr_ex[65]},  '0);
    chk("flush_post_rdy", {62'b0, rdy}, 66'hF);
    chk("flush_err",      {65'b0, err}, '0);
    tick();

    // Mult initiation interval with a waiting packet
    mul_rf = mk(40, 11);
    tick();
    mul_rf = mk(41, 12);
    @(negedge clk);
    chk("mul_c0_rdy0", {65'b0, rdy[0]}, '0);
    chk("mul_c0_out",  mul_ex, mk(40, 11));
    chk("mul_c0_err",  {65'b0, err}, '0);
    tick();
    @(negedge clk);
    chk("mul_c1_rdy0", {65'b0, rdy[0]}, '0);
    chk("mul_c1_out",  mul_ex, '0);
    chk("mul_c1_err",  {65'b0, err}, 66'd1);
    tick();
    @(negedge clk);
    chk("mul_c2_rdy0", {65'b0, rdy[0]}, 66'd1);
    tick();
    mul_rf = '0;
    @(negedge clk);
    chk("mul_c3_out",  mul_ex, mk(41, 12));
    chk("mul_c3_rdy0", {65'b0, rdy[0]}, '0);

    // Asynchronous reset mid-busy, away from any clock edge
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rdy", {62'b0, rdy}, 66'hF);
    chk("arst_mul", mul_ex, '0);
    chk("arst_err", {65'b0, err}, '0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    tick();
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_isu_ex_latch
`default_nettype wire

// File: doc/isu_ex_latch.md
# isu_ex_latch

Issue-to-execute boundary register for the four issue ports (multiplier, ALU1, ALU2, address adder). It captures the 66-bit issue packets produced combinationally by the priority decoder each cycle and holds them for the execute stage. It tracks occupancy of the non-pipelined multiplier and of the stalled address path, and drives the per-unit ready vector the priority decoder consumes the same cycle. It sits directly after the issue-queue selection logic and before register-file read.

## Interface
Parameters:
- IS_INST_WIDTH, 66, issue packet width; bit 65 = inst vld, bits 64:59 = ISQ index, bits 5:0 = freed preg
- ISQ_IDX_BITS_NUM, 6, ISQ index width
- MUL_LAT, 3, multiplier initiation interval in cycles (1 = fully pipelined); legal range 1..15

Ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- mul_ins_to_rf / alu1_ins_to_rf / alu2_ins_to_rf / adr_ins_to_rf  in  66 each  issue packets from the decoder
- mem_stall  in  1  memory side cannot take an address op this cycle
- flush  in  1  mispredict/squash; kills everything in flight
- fun_rdy_frm_exe  out  4  bit0 mult, bit1 ALU1, bit2 ALU2, bit3 addr; 1 = may issue this cycle
- mul_ins_to_ex / alu1_ins_to_ex / alu2_ins_to_ex / adr_ins_to_ex  out  66 each  latched packets
- issue_err  out  1  sticky: a valid packet arrived on a port whose ready was low

## Operation
- Accept per port p: `acc_p = pkt_p[65] & fun_rdy_frm_exe[p]`.
- On acc_p the output register for port p loads pkt_p.
- With no acc_p on ALU1, ALU2 or mult, that output register loads all-zero (bubble).
- Address port hold: with mem_stall high, adr_ins_to_ex holds its value. With mem_stall low and no acc, it loads zero.
- Ready vector, combinational from registered state plus inputs:
  - bit0 = (mul_cnt == 0) & ~flush
  - bit1 = bit2 = ~flush
  - bit3 = ~mem_stall & ~flush
- mul_cnt is a 4-bit down-counter:
  - On acc_0, load MUL_LAT-1.
  - Otherwise, if non-zero, decrement.
  - Reset value 0.
- Flush has highest priority. At the edge it:
  - clears the vld bit (bit 65) of all four output registers, including a held address packet;
  - clears mul_cnt to 0;
  - blocks all accepts (ready is already low).
- issue_err sets when pkt_p[65] & ~fun_rdy_frm_exe[p] for any p, excluding cycles where flush is high. The offending packet is dropped. issue_err clears only on reset.
- mem_stall and flush both high: flush wins, and the address register vld clears.

## Timing
- Reset values: all output packet registers 0, mul_cnt 0, issue_err 0.
- fun_rdy_frm_exe is 4'b1111 during and after reset when flush = mem_stall = 0.
- Latency: packet presented in cycle N appears on *_ins_to_ex after edge N+1 (one register stage).
- Multiplier accepted at edge E:
  - bit0 is low for cycles E..E+MUL_LAT-2;
  - bit0 is high again in cycle E+MUL_LAT-1, so the next accept is at edge E+MUL_LAT-1+1 = E+MUL_LAT.
  - With MUL_LAT = 1, bit0 never drops.
- Ready is combinational from mem_stall/flush into the decoder. This is an intended same-cycle path and carries no register.
- Reset asserted mid-operation clears all state asynchronously. Deassertion is synchronous to clk through the team's standard reset synchroniser, outside this block.

## Structure
- Shared issue package holds:
  - IS_INST_WIDTH, ISQ_IDX_BITS_NUM
  - field positions IS_BIT_INST_VLD (65) and IS_BIT_IDX (64)
  - FUN_MULT_BIT/FUN_ADD1_BIT/FUN_ADD2_BIT/FUN_ADDR_BIT (0..3)
- The decoder uses the same constants.
- One natural sub-module, `isu_port_reg`, is instantiated four times: a 66-bit packet register with accept, hold, and flush-clear-vld controls. The multiplier counter and ready logic stay in the top.

## Test plan
- Reset, all inputs 0 → all outputs 0, fun_rdy_frm_exe = 4'b1111, issue_err = 0.
- Valid packets on all four ports with idx 3/7/8/12 in cycle N → all four appear on outputs after edge N+1. Idle cycle N+1 → ALU/mult/addr outputs return to 0.
- MUL_LAT = 3, mult packet accepted at edge 0, another valid mult held on the input →
  - bit0 low in cycles 0–1, high in cycle 2;
  - second packet latched at edge 3;
  - issue_err set by the offending cycles 0–1.
- mem_stall high 4 cycles after an address accept → adr_ins_to_ex unchanged and bit3 low throughout. mem_stall drop → next address accepted.
- flush during a mult busy window with a held address packet → after the edge:
  - all output vld bits 0;
  - mul_cnt 0 and bit0 high;
  - issue_err unchanged.
- rst_n pulsed low mid-busy (mul_cnt = 2) → immediate return to reset values without waiting for a clock edge.
